// File: rtl/key_event_queue_if.sv
// Event-side bundle of key_event_queue: debounced key levels in, show-ahead event FIFO head out.
// The slave modport is the queue itself; the master modport is the key filter / consumer side.
interface key_event_queue_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]   key_deb;
    logic          ev_ready;
    logic          ev_valid;
    logic [3:0]    ev_code;
    logic          ev_release;
    logic [CW-1:0] ev_count;
    logic          ovf;

    modport master (
        output key_deb,
        output ev_ready,
        input  ev_valid,
        input  ev_code,
        input  ev_release,
        input  ev_count,
        input  ovf
    );

    modport slave (
        input  key_deb,
        input  ev_ready,
        output ev_valid,
        output ev_code,
        output ev_release,
        output ev_count,
        output ovf
    );
endinterface

// File: rtl/key_event_queue.sv
// Turns debounced key levels into press (and optionally release) events queued in a show-ahead FIFO.
// Optional release events are enabled by defining KEY_RELEASE_EVENT_EN.
module key_event_queue #(
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    key_event_queue_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef KEY_RELEASE_EVENT_EN
    localparam int EW = 5;
`else
    localparam int EW = 4;
`endif

    // Lowest pending index wins; at the same index a press is chosen before a release.
    // Result is {found, is_release, code}.
    function automatic logic [5:0] pick_event(input logic [15:0] press, input logic [15:0] rel);
        logic [5:0] r;
        r = 6'd0;
        for (int i = 15; i >= 0; i--) begin
            r = press[i] ? {1'b1, 1'b0, 4'(i)} : (rel[i] ? {1'b1, 1'b1, 4'(i)} : r);
        end
        return r;
    endfunction

    logic [15:0]   key_prev_q;
    logic [15:0]   press_pend_q, press_pend_d;
    logic [15:0]   press_edge_s, press_clr_s;
    logic [15:0]   rel_pend_s;
    logic          rel_ovf_s;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] head_s;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          valid_s, pop_s, push_s, space_s, sel_valid_s;
    logic [4:0]    sel_entry_s;

    // Event selection, press pending update, overflow detection and FIFO bookkeeping.
    always_comb begin
        valid_s      = (count_q != {CW{1'b0}});
        pop_s        = valid_s & bus.ev_ready;
        space_s      = (count_q < DEPTH_C) | pop_s;
        {sel_valid_s, sel_entry_s} = pick_event(press_pend_q, rel_pend_s);
        push_s       = sel_valid_s & space_s;
        press_edge_s = bus.key_deb & ~key_prev_q;
        if (push_s && !sel_entry_s[4]) begin
            press_clr_s = 16'h0001 << sel_entry_s[3:0];
        end else begin
            press_clr_s = 16'h0000;
        end
        // An edge that meets a still-pending, not-being-drained bit is lost.
        press_pend_d = (press_pend_q & ~press_clr_s) | press_edge_s;
        ovf_d        = ovf_q | (|(press_edge_s & press_pend_q & ~press_clr_s)) | rel_ovf_s;
        wr_ptr_d     = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d     = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Key history, pending bits, pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev_q   <= 16'h0000;
            press_pend_q <= 16'h0000;
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            ovf_q        <= 1'b0;
        end else begin
            key_prev_q   <= bus.key_deb;
            press_pend_q <= press_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
        end
    end

    // FIFO storage; stale entries are never visible because the head is gated by valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= sel_entry_s[EW-1:0];
        end
    end

`ifdef KEY_RELEASE_EVENT_EN
    logic [15:0] rel_pend_q, rel_pend_d, rel_edge_s, rel_clr_s;

    // Release pending bits follow the same lost-edge rule as presses.
    always_comb begin
        rel_edge_s = key_prev_q & ~bus.key_deb;
        if (push_s && sel_entry_s[4]) begin
            rel_clr_s = 16'h0001 << sel_entry_s[3:0];
        end else begin
            rel_clr_s = 16'h0000;
        end
        rel_pend_d = (rel_pend_q & ~rel_clr_s) | rel_edge_s;
        rel_ovf_s  = |(rel_edge_s & rel_pend_q & ~rel_clr_s);
    end

    // Release pending register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rel_pend_q <= 16'h0000;
        end else begin
            rel_pend_q <= rel_pend_d;
        end
    end

    assign rel_pend_s     = rel_pend_q;
    assign head_s         = mem_q[rd_ptr_q];
    assign bus.ev_release = valid_s & head_s[4];
`else
    assign rel_pend_s     = 16'h0000;
    assign rel_ovf_s      = 1'b0;
    assign head_s         = mem_q[rd_ptr_q];
    assign bus.ev_release = 1'b0;
`endif

    assign bus.ev_valid = valid_s;
    assign bus.ev_code  = valid_s ? head_s[3:0] : 4'h0;
    assign bus.ev_count = count_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_key_event_queue.sv
// Directed and randomized bench for key_event_queue, checked against a queue-based event model.
module tb_key_event_queue;
    localparam int DEPTH = 4;
`ifdef KEY_RELEASE_EVENT_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    typedef struct {
        int code;
        bit rel;
    } ev_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n7;

    bit [15:0] m_prev, m_pp, m_rp;
    bit        m_ovf;
    ev_t       mq[$];

    key_event_queue_if #(.FIFO_DEPTH(DEPTH)) bus ();

    key_event_queue #(.FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the event rules, using the inputs currently driven.
    task automatic model_step();
        bit   pop, space, found;
        ev_t  e;
        if (rst) begin
            m_prev = '0; m_pp = '0; m_rp = '0; m_ovf = 0;
            mq.delete();
            return;
        end
        pop   = (mq.size() > 0) && bus.ev_ready;
        space = (mq.size() < DEPTH) || pop;
        found = 0;
        e.code = 0; e.rel = 0;
        for (int i = 0; i < 16; i++) begin
            if (!found && m_pp[i]) begin
                found = 1; e.code = i; e.rel = 0;
            end else if (!found && REL_EN && m_rp[i]) begin
                found = 1; e.code = i; e.rel = 1;
            end
        end
        if (found && space) begin
            if (e.rel) m_rp[e.code] = 0;
            else       m_pp[e.code] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            if (bus.key_deb[i] && !m_prev[i]) begin
                if (m_pp[i]) m_ovf = 1;
                else         m_pp[i] = 1;
            end
            if (REL_EN && !bus.key_deb[i] && m_prev[i]) begin
                if (m_rp[i]) m_ovf = 1;
                else         m_rp[i] = 1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (found && space) mq.push_back(e);
        m_prev = bus.key_deb;
    endtask

    task automatic tick();
        int  ec;
        bit  er;
        model_step();
        @(posedge clk);
        #1;
        ec = (mq.size() > 0) ? mq[0].code : 0;
        er = (mq.size() > 0) ? mq[0].rel : 1'b0;
        chk("valid",   32'(bus.ev_valid),   32'(mq.size() > 0));
        chk("count",   32'(bus.ev_count),   32'(mq.size()));
        chk("code",    32'(bus.ev_code),    32'(ec));
        chk("release", 32'(bus.ev_release), 32'(er));
        chk("ovf",     32'(bus.ovf),        32'(m_ovf));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_prev = '0; m_pp = '0; m_rp = '0; m_ovf = 0;
        rst = 1'b1;
        bus.key_deb  = 16'h0000;
        bus.ev_ready = 1'b0;

        // Reset state
        tick();
        chk("reset_valid", 32'(bus.ev_valid), 32'd0);
        chk("reset_count", 32'(bus.ev_count), 32'd0);
        rst = 1'b0;

        // Single key, two-edge latency
        bus.key_deb = 16'h0020;
        tick();
        chk("single_lat_e0", 32'(bus.ev_valid), 32'd0);
        tick();
        chk("single_valid", 32'(bus.ev_valid), 32'd1);
        chk("single_code", 32'(bus.ev_code), 32'd5);
        chk("single_rel", 32'(bus.ev_release), 32'd0);
        chk("single_count", 32'(bus.ev_count), 32'd1);
        bus.key_deb  = 16'h0000;
        bus.ev_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Simultaneous presses pop in ascending order
        bus.key_deb = 16'h4204;
        tick();
        tick();
        chk("simul_first", 32'(bus.ev_code), 32'd2);
        tick();
        chk("simul_second", 32'(bus.ev_code), 32'd9);
        tick();
        chk("simul_third", 32'(bus.ev_code), 32'd14);
        chk("simul_ovf", 32'(bus.ovf), 32'd0);
        bus.key_deb = 16'h0000;
        for (int i = 0; i < 8; i++) tick();

        // Full FIFO with simultaneous push and pop
        rst = 1'b1;
        bus.ev_ready = 1'b0;
        tick();
        rst = 1'b0;
        bus.key_deb = 16'h003F;
        for (int i = 0; i < 6; i++) tick();
        chk("full_count", 32'(bus.ev_count), 32'd4);
        chk("full_head", 32'(bus.ev_code), 32'd0);
        bus.ev_ready = 1'b1;
        tick();
        bus.ev_ready = 1'b0;
        chk("full_pushpop_count", 32'(bus.ev_count), 32'd4);
        chk("full_pushpop_head", 32'(bus.ev_code), 32'd1);

        // Overflow on key 7 while the FIFO is full
        bus.key_deb = 16'h00BF;
        tick();
        bus.key_deb = 16'h003F;
        tick();
        bus.key_deb = 16'h00BF;
        tick();
        chk("ovf_set", 32'(bus.ovf), 32'd1);
        bus.ev_ready = 1'b1;
        n7 = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.ev_valid && bus.ev_code == 4'd7 && !bus.ev_release) n7++;
            tick();
        end
        chk("ovf_single_key7", 32'(n7), 32'd1);
        chk("ovf_sticky", 32'(bus.ovf), 32'd1);

        // Press then release key 3
        rst = 1'b1;
        bus.ev_ready = 1'b0;
        bus.key_deb = 16'h0000;
        tick();
        rst = 1'b0;
        bus.key_deb = 16'h0008;
        tick();
        bus.key_deb = 16'h0000;
        for (int i = 0; i < 4; i++) tick();
        chk("rel_count", 32'(bus.ev_count), REL_EN ? 32'd2 : 32'd1);
        chk("rel_first_code", 32'(bus.ev_code), 32'd3);
        chk("rel_first_type", 32'(bus.ev_release), 32'd0);
        bus.ev_ready = 1'b1;
        tick();
        bus.ev_ready = 1'b0;
        chk("rel_second_valid", 32'(bus.ev_valid), 32'(REL_EN));
        chk("rel_second_type", 32'(bus.ev_release), 32'(REL_EN));
        chk("rel_second_code", 32'(bus.ev_code), REL_EN ? 32'd3 : 32'd0);

        // Reset mid-operation with key 1 held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.key_deb = 16'h0172;
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_pre_count", 32'(bus.ev_count), 32'd3);
        bus.key_deb = 16'h0002;
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(bus.ev_valid), 32'd0);
        chk("midrst_count", 32'(bus.ev_count), 32'd0);
        chk("midrst_code", 32'(bus.ev_code), 32'd0);
        chk("midrst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;
        tick();
        chk("midrst_lat", 32'(bus.ev_valid), 32'd0);
        tick();
        chk("midrst_key1_valid", 32'(bus.ev_valid), 32'd1);
        chk("midrst_key1_code", 32'(bus.ev_code), 32'd1);
        chk("midrst_key1_rel", 32'(bus.ev_release), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("midrst_key1_once", 32'(bus.ev_count), 32'd1);

        // Randomized key activity, consumer stalls and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.key_deb[$urandom_range(0, 15)] = ~bus.key_deb[$urandom_range(0, 15)];
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.key_deb = bus.key_deb ^ 16'($urandom_range(0, 65535));
            end
            bus.ev_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, event FIFO depth; legal values are powers of two from 2 to 16.
REQ-002 Port: clk  input  1  system clock; all logic is on the rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: key_deb  input  16  debounced key levels from the key filter stage; 1 means pressed; bit i is key code i.
REQ-005 Port: ev_ready  input  1  consumer accepts the head event.
REQ-006 Port: ev_valid  output  1  FIFO non-empty; head event presented.
REQ-007 Port: ev_code  output  4  key index of the head event.
REQ-008 Port: ev_release  output  1  head event type: 1 means release, 0 means press.
REQ-009 Port: ev_count  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-010 Port: ovf  output  1  sticky flag; an edge was lost.

Function
REQ-011 The block SHALL register key_deb into key_prev every cycle; press_edge[i] = key_deb[i] & ~key_prev[i].
REQ-012 Each cycle, the block SHALL set press_pend[i] on press_edge[i]; pending bits persist until their event is written to the FIFO.
REQ-013 A press_edge[i] arriving while press_pend[i] is already set and not being cleared that cycle SHALL set ovf; the edge is lost and the pending bit stays 1.
REQ-014 Each cycle with FIFO space, the block SHALL write exactly one pending event and clear its pending bit: the lowest set index wins; at equal index, press beats release.
REQ-015 FIFO space exists when ev_count < FIFO_DEPTH, or when a pop occurs in the same cycle (full with simultaneous push and pop: both occur, ev_count unchanged).
REQ-016 Pop SHALL occur when ev_valid & ev_ready; ev_ready while empty has no effect.
REQ-017 The FIFO SHALL be show-ahead: ev_code and ev_release reflect the head entry combinationally from registers; both read 0 when empty.
REQ-018 Latency: a key_deb bit first sampled high at edge E0 sets pend at E0, is written at E1, and ev_valid=1 follows E1 when the FIFO was empty and no lower index was pending.
REQ-019 ev_valid SHALL equal (ev_count != 0); ev_count SHALL change by +1 on push only, by -1 on pop only, and be unchanged on both or neither.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH; ev_count never exceeds FIFO_DEPTH.
REQ-021 Order: FIFO output order SHALL equal write order; events pending on the same cycle are written in ascending index order.
REQ-022 ovf SHALL remain 1 until reset.

Reset
REQ-023 While rst=1 at a clock edge: key_prev=16'h0000, all pending bits=0, FIFO pointers=0, ev_count=0, ev_valid=0, ev_code=0, ev_release=0, ovf=0.
REQ-024 Reset asserted mid-operation SHALL discard queued and pending events within the same edge.
REQ-025 Keys held through reset SHALL produce press events after reset deasserts, because key_prev resets to 0.

Configuration
REQ-026 Macro KEY_RELEASE_EVENT_EN: when defined, the block SHALL keep rel_pend[i], set on key_prev[i] & ~key_deb[i], with overflow rules identical to REQ-013; release events carry ev_release=1.
REQ-027 When KEY_RELEASE_EVENT_EN is undefined, releases SHALL be ignored, no release pending logic SHALL exist, and ev_release SHALL be tied to 0.

Verification
REQ-028 Directed test, single key: hold ev_ready=0, raise key_deb[5] -> ev_valid=1 two edges later, ev_code=5, ev_release=0, ev_count=1.
REQ-029 Directed test, simultaneous presses: raise keys 9, 2 and 14 in the same cycle with ev_ready=1 -> events popped in order 2, 9, 14 on consecutive cycles, ovf=0.
REQ-030 Directed test, full FIFO (FIFO_DEPTH=4, ev_ready=0): press keys 0..5 -> ev_count=4 holding 0,1,2,3, pend bits 4 and 5 held; then ev_ready=1 for one cycle -> pop 0 and push 4 in the same edge, ev_count stays 4.
REQ-031 Directed test, overflow (FIFO full, ev_ready=0): press key 7, release, press again -> ovf=1 and only one key-7 press is queued (without the macro).
REQ-032 Directed test, macro on: press then release key 3 -> events (3,press) then (3,release); with the macro off only (3,press) appears.
REQ-033 Directed test, reset mid-operation: assert rst with ev_count=3 and pending bits set, with key 1 held -> all outputs 0 after the edge; after deassert, one press event for key 1 appears.
